// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and defaults for the store-and-forward AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Write-side state: ACCEPT stores beats, DROP swallows the rest of an oversize packet.
  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_sp_ram.sv
// Simple dual-port buffer: one synchronous write port, one asynchronous read port.
module axis_sp_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and the pointers (which are reset) define what is valid.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward packet FIFO: a packet is visible on m_* only once its last
// beat is stored; packets longer than the buffer are discarded whole.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [ADDR_W:0]   pkt_count,
  output logic [7:0]        drop_count
);

  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  wr_state_e         state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]   pkt_count_q, pkt_count_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;
  logic              rdy_en_q, rdy_en_d;

  logic [ADDR_W:0]   used;
  logic              full;
  logic              s_hs;
  logic              mem_we;
  logic              rd_load;
  logic              pkt_inc;
  logic              pkt_dec;
  logic [DATA_W:0]   rd_word;

  // Occupancy is derived from registered pointers, so s_ready never depends on
  // a same-cycle read freeing an entry.
  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (used == FULL_LVL);
  assign s_ready = rdy_en_q && ((state_q == ST_DROP) || !full);
  assign s_hs    = s_valid && s_ready;
  assign mem_we  = s_hs && (state_q == ST_ACCEPT);

  axis_sp_ram #(
    .WIDTH  (DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata ({s_last, s_data}),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  // Next-state logic: write FSM, read-side output register and counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (that would infer a latch).
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q;
    rdy_en_d     = 1'b1;
    pkt_inc      = 1'b0;

    case (state_q)
      ST_ACCEPT: begin
        if (s_hs) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (s_last) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            pkt_inc      = 1'b1;
          end
        end else if (full && (commit_ptr_q == rd_ptr_q)) begin
          // The whole buffer is one unterminated packet: discard it.
          wr_ptr_d     = commit_ptr_q;
          drop_count_d = sat_inc8(drop_count_q);
          state_d      = ST_DROP;
        end
      end
      ST_DROP: begin
        if (s_hs && s_last) state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase

    // Output register never runs past the last committed packet.
    rd_load = (!m_valid_q || m_ready) && (rd_ptr_q != commit_ptr_q);
    if (rd_load) begin
      m_data_d  = rd_word[DATA_W-1:0];
      m_last_d  = rd_word[DATA_W];
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    pkt_dec = m_valid_q && m_ready && m_last_q;
    if (pkt_inc && !pkt_dec)      pkt_count_d = pkt_count_q + PTR_ONE;
    else if (!pkt_inc && pkt_dec) pkt_count_d = pkt_count_q - PTR_ONE;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACCEPT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      rdy_en_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      rdy_en_q     <= rdy_en_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign m_valid    = m_valid_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: each scenario task drives stimulus and
// compares outputs against hand-computed values.
module tb_axis_pkt_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_last = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;
  logic [4:0] pkt_count;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_data[$];
  logic       rx_last[$];

  axis_pkt_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_last     (s_last),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Record every output beat that will handshake at the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (reset && m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat at a falling edge and return at the falling edge after it is accepted.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (s_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: s_ready=%b required 1 for beat %h", s_ready, d);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
    wait_neg(2);
    reset = 1'b1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_rel_s_ready_pre: got %b want 0", s_ready); end
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_rel_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    rx_data.delete(); rx_last.delete();
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b0);
    send_beat(8'hCC, 1'b1);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_lat_pre: m_valid got %b want 0", m_valid); end
    n_cmp++; if (pkt_count !== 5'd1) begin n_err++; $display("FAIL single_pkt1: got %0d want 1", pkt_count); end
    @(negedge clk);
    n_cmp++; if ({m_valid, m_data, m_last} !== {1'b1, 8'hAA, 1'b0}) begin n_err++; $display("FAIL single_b0: got v%b %h l%b want v1 AA l0", m_valid, m_data, m_last); end
    @(negedge clk);
    n_cmp++; if ({m_valid, m_data, m_last} !== {1'b1, 8'hBB, 1'b0}) begin n_err++; $display("FAIL single_b1: got v%b %h l%b want v1 BB l0", m_valid, m_data, m_last); end
    @(negedge clk);
    n_cmp++; if ({m_valid, m_data, m_last} !== {1'b1, 8'hCC, 1'b1}) begin n_err++; $display("FAIL single_b2: got v%b %h l%b want v1 CC l1", m_valid, m_data, m_last); end
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_end_valid: got %b want 0", m_valid); end
    n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL single_pkt0: got %0d want 0", pkt_count); end
  endtask

  task automatic test_two_pkts();
    logic [7:0] exp_d [5];
    logic       exp_l [5];
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    m_ready = 1'b0;
    rx_data.delete(); rx_last.delete();
    for (int i = 0; i < 5; i++) send_beat(exp_d[i], exp_l[i]);
    n_cmp++; if (pkt_count !== 5'd2) begin n_err++; $display("FAIL two_pkt2: got %0d want 2", pkt_count); end
    n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL two_head: got v%b %h want v1 01", m_valid, m_data); end
    wait_neg(2);
    n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL two_stall: got v%b %h want v1 01", m_valid, m_data); end
    m_ready = 1'b1;
    wait_neg(8);
    n_cmp++; if (rx_data.size() != 5) begin n_err++; $display("FAIL two_count: got %0d beats want 5", rx_data.size()); end
    for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
      n_cmp++;
      if ({rx_data[i], rx_last[i]} !== {exp_d[i], exp_l[i]}) begin
        n_err++; $display("FAIL two_beat%0d: got %h l%b want %h l%b", i, rx_data[i], rx_last[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL two_pkt0: got %0d want 0", pkt_count); end
  endtask

  task automatic test_full16();
    m_ready = 1'b0;
    rx_data.delete(); rx_last.delete();
    for (int i = 0; i < 16; i++) send_beat(8'h40 + 8'(i), (i == 15));
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full16_sready: got %b want 0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL full16_valid_pre: got %b want 0", m_valid); end
    n_cmp++; if (pkt_count !== 5'd1) begin n_err++; $display("FAIL full16_pkt: got %0d want 1", pkt_count); end
    @(negedge clk);
    n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h40}) begin n_err++; $display("FAIL full16_head: got v%b %h want v1 40", m_valid, m_data); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL full16_sready_after_read: got %b want 1", s_ready); end
    m_ready = 1'b1;
    wait_neg(20);
    n_cmp++; if (rx_data.size() != 16) begin n_err++; $display("FAIL full16_count: got %0d beats want 16", rx_data.size()); end
    for (int i = 0; i < 16 && i < rx_data.size(); i++) begin
      n_cmp++;
      if ({rx_data[i], rx_last[i]} !== {8'h40 + 8'(i), (i == 15)}) begin
        n_err++; $display("FAIL full16_beat%0d: got %h l%b want %h l%b", i, rx_data[i], rx_last[i], 8'h40 + 8'(i), (i == 15));
      end
    end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL full16_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_drop20();
    m_ready = 1'b0;
    rx_data.delete(); rx_last.delete();
    for (int i = 0; i < 16; i++) send_beat(8'h60 + 8'(i), 1'b0);
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL drop_full_sready: got %b want 0", s_ready); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL drop_cnt_pre: got %0d want 0", drop_count); end
    @(negedge clk);
    n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL drop_cnt: got %0d want 1", drop_count); end
    n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL drop_pkt: got %0d want 0", pkt_count); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid: got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL drop_sready: got %b want 1", s_ready); end
    for (int i = 16; i < 20; i++) send_beat(8'h60 + 8'(i), (i == 19));
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    m_ready = 1'b1;
    wait_neg(6);
    n_cmp++; if (rx_data.size() != 2) begin n_err++; $display("FAIL drop_next_count: got %0d beats want 2", rx_data.size()); end
    if (rx_data.size() == 2) begin
      n_cmp++; if ({rx_data[0], rx_last[0]} !== {8'h11, 1'b0}) begin n_err++; $display("FAIL drop_next_b0: got %h l%b want 11 l0", rx_data[0], rx_last[0]); end
      n_cmp++; if ({rx_data[1], rx_last[1]} !== {8'h22, 1'b1}) begin n_err++; $display("FAIL drop_next_b1: got %h l%b want 22 l1", rx_data[1], rx_last[1]); end
    end
    n_cmp++; if ({drop_count, pkt_count} !== {8'd1, 5'd0}) begin n_err++; $display("FAIL drop_end_counts: got drop %0d pkt %0d want 1 0", drop_count, pkt_count); end
  endtask

  task automatic test_toggle();
    logic [7:0] exp_d [4];
    exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    m_ready = 1'b0;
    rx_data.delete(); rx_last.delete();
    for (int i = 0; i < 4; i++) send_beat(exp_d[i], (i == 3));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        n_cmp++;
        if (rx_data.size() >= 4) begin
          n_err++; $display("FAIL toggle_extra: beat %h valid after 4 beats emitted", m_data);
        end else if ({m_data, m_last} !== {exp_d[rx_data.size()], (rx_data.size() == 3)}) begin
          n_err++; $display("FAIL toggle_cyc%0d: got %h l%b want %h", k, m_data, m_last, exp_d[rx_data.size()]);
        end
      end
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_neg(3);
    n_cmp++; if (rx_data.size() != 4) begin n_err++; $display("FAIL toggle_count: got %0d beats want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      n_cmp++;
      if ({rx_data[i], rx_last[i]} !== {exp_d[i], (i == 3)}) begin
        n_err++; $display("FAIL toggle_beat%0d: got %h l%b want %h l%b", i, rx_data[i], rx_last[i], exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    send_beat(8'h71, 1'b0);
    send_beat(8'h72, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_sready: got %b want 0", s_ready); end
    n_cmp++; if ({m_valid, m_data, m_last} !== 10'd0) begin n_err++; $display("FAIL mid_rst_m: got v%b %h l%b want all 0", m_valid, m_data, m_last); end
    n_cmp++; if ({pkt_count, drop_count} !== 13'd0) begin n_err++; $display("FAIL mid_rst_counts: got pkt %0d drop %0d want 0 0", pkt_count, drop_count); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_sready: got %b want 1", s_ready); end
    rx_data.delete(); rx_last.delete();
    send_beat(8'h81, 1'b0);
    send_beat(8'h82, 1'b1);
    wait_neg(5);
    n_cmp++; if (rx_data.size() != 2) begin n_err++; $display("FAIL mid_count: got %0d beats want 2", rx_data.size()); end
    if (rx_data.size() == 2) begin
      n_cmp++; if ({rx_data[0], rx_last[0], rx_data[1], rx_last[1]} !== {8'h81, 1'b0, 8'h82, 1'b1}) begin
        n_err++; $display("FAIL mid_data: got %h l%b %h l%b want 81 l0 82 l1", rx_data[0], rx_last[0], rx_data[1], rx_last[1]);
      end
    end
    n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL mid_pkt: got %0d want 0", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pkts();
    test_full16();
    test_drop20();
    test_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
